pc_fetch_ctrl: RTL and testbench

- Sequences the program counter and the instruction memory for the PC/IMEM/ID path.
- Holds the architectural PC and issues one IMEM read per instruction.
- Waits a fixed IMEM latency, then presents the fetched word to decode over a valid/ready handshake.
- Applies branch redirects from decode; non-pipelined, at most one fetch in flight.

---
 rtl/pcimid_pkg.sv | 24 ++
 rtl/pc_next_unit.sv | 27 ++
 rtl/pc_fetch_ctrl.sv | 120 ++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pcimid_pkg.sv
// pcimid_pkg: shared types and constants for the PC/IMEM/ID fetch path.
package pcimid_pkg;

    localparam int DEF_PC_W    = 8;
    localparam int DEF_INSTR_W = 32;
    localparam int LAT_W       = 2;

    localparam logic [DEF_INSTR_W-1:0] HALT_INSTR = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD,
        ST_HALTED
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_BR
    } pc_sel_e;

endpackage

// File: rtl/pc_next_unit.sv
// pc_next_unit: next-PC select (hold / +1 / branch target) and the PC register.
module pc_next_unit
    import pcimid_pkg::*;
#(
    parameter int PC_W     = DEF_PC_W,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  pc_sel_e         pc_sel,
    input  logic [PC_W-1:0] br_target,
    output logic [PC_W-1:0] pc_q
);

    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = (pc_sel == PC_BR)  ? br_target :
               (pc_sel == PC_INC) ? pc_q + PC_W'(1) : pc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= PC_W'(RESET_PC);
        else     pc_q <= pc_d;
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: non-pipelined fetch sequencer; one IMEM read in flight, valid/ready to decode.
// Define PC_FETCH_HALT_EN to stop in HALTED when an all-ones word is fetched.
module pc_fetch_ctrl
    import pcimid_pkg::*;
#(
    parameter int PC_W     = DEF_PC_W,
    parameter int INSTR_W  = DEF_INSTR_W,
    parameter int IMEM_LAT = 1,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    output logic [PC_W-1:0]    pc_out,
    output logic               imem_rd_en,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               br_valid,
    input  logic [PC_W-1:0]    br_target,
    output logic               busy,
    output logic               halted
);

    fetch_state_e       state_q, state_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic               stop_pend_q, stop_pend_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    ipc_q, ipc_d;
    logic [PC_W-1:0]    pc_q;
    pc_sel_e            pc_sel;
    logic               stop_now;
    logic               is_halt;

    pc_next_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc (
        .clk       (clk),
        .rst       (rst),
        .pc_sel    (pc_sel),
        .br_target (br_target),
        .pc_q      (pc_q)
    );

    assign stop_now = stop_pend_q | stop;
`ifdef PC_FETCH_HALT_EN
    assign is_halt = &imem_rdata;
`else
    assign is_halt = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        instr_d     = instr_q;
        ipc_d       = ipc_q;
        pc_sel      = PC_HOLD;
        stop_pend_d = (state_q != ST_IDLE) && stop_now;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (br_valid) begin
                    pc_sel  = PC_BR;
                    state_d = stop_now ? ST_IDLE : ST_ISSUE;
                end else begin
                    lat_cnt_d = LAT_W'(IMEM_LAT - 1);
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (br_valid) begin
                    pc_sel  = PC_BR;
                    state_d = stop_now ? ST_IDLE : ST_ISSUE;
                end else if (lat_cnt_q != '0) begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end else begin
                    instr_d = imem_rdata;
                    ipc_d   = pc_q;
                    state_d = is_halt ? ST_HALTED : ST_HOLD;
                end
            end
            ST_HOLD: begin
                // A redirect wins over PC+1 whether or not the word is accepted
                if (br_valid || instr_ready) begin
                    pc_sel  = br_valid ? PC_BR : PC_INC;
                    state_d = stop_now ? ST_IDLE : ST_ISSUE;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
        if (state_d == ST_IDLE) stop_pend_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lat_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
            instr_q     <= '0;
            ipc_q       <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            stop_pend_q <= stop_pend_d;
            instr_q     <= instr_d;
            ipc_q       <= ipc_d;
        end
    end

    assign pc_out      = pc_q;
    assign imem_rd_en  = (state_q == ST_ISSUE);
    assign instr_valid = (state_q == ST_HOLD);
    assign instr_out   = instr_q;
    assign instr_pc    = ipc_q;
    assign busy        = (state_q != ST_IDLE);
    assign halted      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed bench for pc_fetch_ctrl with a 1-cycle IMEM model.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, stop, instr_ready, br_valid;
    logic [7:0]  br_target, pc_out, instr_pc;
    logic        imem_rd_en, instr_valid, busy, halted;
    logic [31:0] imem_rdata, instr_out;
    logic        halt_mode = 1'b0;
    int          n_chk = 0, n_fail = 0, hs9 = 0;

    pc_fetch_ctrl dut (
        .clk (clk), .rst (rst), .start (start), .stop (stop),
        .pc_out (pc_out), .imem_rd_en (imem_rd_en), .imem_rdata (imem_rdata),
        .instr_valid (instr_valid), .instr_ready (instr_ready), .instr_out (instr_out),
        .instr_pc (instr_pc), .br_valid (br_valid), .br_target (br_target),
        .busy (busy), .halted (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_rd_en)
            imem_rdata <= (halt_mode && pc_out == 8'd3) ? 32'hFFFF_FFFF : 32'h1000_0000 + {24'd0, pc_out};
        if (instr_valid && instr_ready && instr_pc == 8'h09) hs9 <= hs9 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered in ISSUE for exp_pc with instr_ready=1; leaves in the next ISSUE.
    task automatic one_fetch(input logic [7:0] exp_pc);
        chk("issue_rd_en", {31'd0, imem_rd_en}, 32'd1);
        chk("issue_pc", {24'd0, pc_out}, {24'd0, exp_pc});
        tick();
        chk("wait_rd_en", {31'd0, imem_rd_en}, 32'd0);
        chk("wait_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("hold_valid", {31'd0, instr_valid}, 32'd1);
        chk("hold_instr", instr_out, 32'h1000_0000 + {24'd0, exp_pc});
        chk("hold_ipc", {24'd0, instr_pc}, {24'd0, exp_pc});
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; instr_ready = 1'b0;
        br_valid = 1'b0; br_target = 8'h00;
        repeat (3) tick();
        chk("rst_pc", {24'd0, pc_out}, 32'd0);
        chk("rst_rd_en", {31'd0, imem_rd_en}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        rst = 1'b0; start = 1'b1; instr_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_issue", {31'd0, busy}, 32'd1);
        one_fetch(8'd0);
        one_fetch(8'd1);
        one_fetch(8'd2);
        // decode stall in HOLD at PC 3
        instr_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_instr", instr_out, 32'h1000_0003);
            chk("stall_rd_en", {31'd0, imem_rd_en}, 32'd0);
            chk("stall_pc", {24'd0, pc_out}, 32'd3);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        chk("after_stall_pc", {24'd0, pc_out}, 32'd4);
        one_fetch(8'd4);
        // redirect during WAIT at PC 5
        tick();
        br_valid = 1'b1; br_target = 8'h40;
        tick();
        br_valid = 1'b0;
        chk("wait_br_valid", {31'd0, instr_valid}, 32'd0);
        one_fetch(8'h40);
        // redirect during ISSUE at 0x41 to 9
        br_valid = 1'b1; br_target = 8'h09;
        tick();
        br_valid = 1'b0;
        chk("issue_br_valid", {31'd0, instr_valid}, 32'd0);
        chk("issue_br_pc", {24'd0, pc_out}, 32'd9);
        tick();
        tick();
        chk("hold9_valid", {31'd0, instr_valid}, 32'd1);
        chk("hold9_instr", instr_out, 32'h1000_0009);
        br_valid = 1'b1; br_target = 8'h20;
        tick();
        br_valid = 1'b0;
        chk("br_ready_pc", {24'd0, pc_out}, 32'h20);
        one_fetch(8'h20);
        chk("hs9_once", hs9, 32'd1);
        // redirect in HOLD without ready squashes the held word
        instr_ready = 1'b0;
        tick();
        tick();
        chk("hold21_valid", {31'd0, instr_valid}, 32'd1);
        br_valid = 1'b1; br_target = 8'hFF;
        tick();
        br_valid = 1'b0; instr_ready = 1'b1;
        chk("squash_valid", {31'd0, instr_valid}, 32'd0);
        one_fetch(8'hFF);
        chk("wrap_pc", {24'd0, pc_out}, 32'd0);
        // stop latched in ISSUE, honoured at the handshake
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        chk("stop_hold_valid", {31'd0, instr_valid}, 32'd1);
        tick();
        chk("stop_busy", {31'd0, busy}, 32'd0);
        chk("stop_pc", {24'd0, pc_out}, 32'd1);
        tick();
        chk("stop_idle_rd_en", {31'd0, imem_rd_en}, 32'd0);
        // async reset mid-WAIT
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("arst_pc", {24'd0, pc_out}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        tick();
        tick();
        chk("arst_valid", {31'd0, instr_valid}, 32'd0);
        rst = 1'b0;
        // branch ignored in IDLE, and alongside start
        br_valid = 1'b1; br_target = 8'h33;
        tick();
        chk("idle_br_busy", {31'd0, busy}, 32'd0);
        chk("idle_br_pc", {24'd0, pc_out}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0; br_valid = 1'b0;
        one_fetch(8'd0);
        // all-ones word at PC 3
        rst = 1'b1;
        tick();
        rst = 1'b0; halt_mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        one_fetch(8'd0);
        one_fetch(8'd1);
        one_fetch(8'd2);
        chk("pc3", {24'd0, pc_out}, 32'd3);
        tick();
        tick();
`ifdef PC_FETCH_HALT_EN
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_valid", {31'd0, instr_valid}, 32'd0);
        start = 1'b1; br_valid = 1'b1; br_target = 8'h55;
        repeat (3) tick();
        start = 1'b0; br_valid = 1'b0;
        chk("halt_stuck", {31'd0, halted}, 32'd1);
        chk("halt_pc", {24'd0, pc_out}, 32'd3);
        chk("halt_rd_en", {31'd0, imem_rd_en}, 32'd0);
        rst = 1'b1;
        #1;
        chk("halt_rst", {31'd0, halted}, 32'd0);
        rst = 1'b0;
`else
        chk("ones_halted", {31'd0, halted}, 32'd0);
        chk("ones_valid", {31'd0, instr_valid}, 32'd1);
        chk("ones_instr", instr_out, 32'hFFFF_FFFF);
        chk("ones_ipc", {24'd0, instr_pc}, 32'd3);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
